// File: rtl/risc_toy_pkg.sv
// Shared types and constants for the toy RISC memory arbiter.
// Holds the arbiter state encoding, default bus widths and the timeout read fill.
package risc_toy_pkg;

    localparam int DEF_AW = 30;
    localparam int DEF_DW = 32;

    // Every bit of the read data returned on a timed-out read takes this value.
    localparam logic TMO_RDATA_BIT = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/risc_toy_tmo_cnt.sv
// Memory-ack watchdog: counts stalled grant cycles and flags the TMO-th one.
// expired_o is combinational so the FSM can leave on the very cycle the limit is hit.
module risc_toy_tmo_cnt #(
    parameter int TMO = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TMO + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CW'(TMO))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Asserted during the TMO-th stalled cycle; an M_ACK in that cycle masks it.
    assign expired_o = en_i && !clr_i && (cnt_q == CW'(TMO - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/risc_toy_mem_arb.sv
// Two-master (fetch/data) arbiter onto one memory port, D-priority with a bounded D run.
// Every output is registered; the completion cycle arbitrates nobody, so a held REQ is not re-granted.
module risc_toy_mem_arb
    import risc_toy_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int MAX_D_RUN = 4,
    parameter int TMO       = 64
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          I_REQ,
    input  logic [AW-1:0] I_ADDR,
    output logic [DW-1:0] I_RDATA,
    output logic          I_ACK,
    input  logic          D_REQ,
    input  logic          D_RW,
    input  logic [AW-1:0] D_ADDR,
    input  logic [DW-1:0] D_WDATA,
    output logic [DW-1:0] D_RDATA,
    output logic          D_ACK,
    output logic          M_REQ,
    output logic          M_RW,
    output logic [AW-1:0] M_ADDR,
    output logic [DW-1:0] M_WDATA,
    input  logic [DW-1:0] M_RDATA,
    input  logic          M_ACK,
    output logic          BUSY,
    output logic          TMO_ERR
);

    localparam int RW = $clog2(MAX_D_RUN + 1);

    arb_state_t    state_q;
    logic [RW-1:0] d_run_q;
    logic [RW-1:0] d_run_d;
    logic          arb_ok;
    logic          grant_d;
    logic          grant_i;
    logic          in_grant;
    logic          tmo_expired;
    logic [DW-1:0] done_rdata;

    // Whoever is being acked still holds REQ this cycle; skipping arbitration
    // here also keeps a waiting I from breaking into a back-to-back D run.
    assign arb_ok   = !I_ACK && !D_ACK;
    assign grant_d  = (state_q == IDLE) && arb_ok && D_REQ &&
                      ((d_run_q < RW'(MAX_D_RUN)) || !I_REQ);
    assign grant_i  = (state_q == IDLE) && arb_ok && !grant_d && I_REQ;
    assign in_grant = (state_q != IDLE);
    assign BUSY     = in_grant;

    assign done_rdata = M_ACK ? M_RDATA : {DW{TMO_RDATA_BIT}};

    always_comb begin
        d_run_d = d_run_q;
        if (grant_i) begin
            d_run_d = '0;
        end else if (grant_d) begin
            if (!I_REQ) begin
                d_run_d = '0;
            end else if (d_run_q < RW'(MAX_D_RUN)) begin
                d_run_d = d_run_q + 1'b1;
            end
        end
    end

    risc_toy_tmo_cnt #(
        .TMO (TMO)
    ) u_tmo_cnt (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clr_i     (grant_d || grant_i),
        .en_i      (in_grant && !M_ACK),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            d_run_q <= '0;
            M_REQ   <= 1'b0;
            M_RW    <= 1'b0;
            M_ADDR  <= '0;
            M_WDATA <= '0;
            I_RDATA <= '0;
            D_RDATA <= '0;
            I_ACK   <= 1'b0;
            D_ACK   <= 1'b0;
            TMO_ERR <= 1'b0;
        end else begin
            I_ACK   <= 1'b0;
            D_ACK   <= 1'b0;
            d_run_q <= d_run_d;
            unique case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q <= GRANT_D;
                        M_REQ   <= 1'b1;
                        M_RW    <= D_RW;
                        M_ADDR  <= D_ADDR;
                        M_WDATA <= D_WDATA;
                    end else if (grant_i) begin
                        state_q <= GRANT_I;
                        M_REQ   <= 1'b1;
                        M_RW    <= 1'b0;
                        M_ADDR  <= I_ADDR;
                        M_WDATA <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (M_ACK || tmo_expired) begin
                        state_q <= IDLE;
                        M_REQ   <= 1'b0;
                        if (!M_ACK) begin
                            TMO_ERR <= 1'b1;
                        end
                        if (state_q == GRANT_I) begin
                            I_ACK   <= 1'b1;
                            I_RDATA <= done_rdata;
                        end else begin
                            D_ACK <= 1'b1;
                            if (!M_RW) begin
                                D_RDATA <= done_rdata;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_toy_mem_arb.sv
// Directed bench for risc_toy_mem_arb: scoreboarded grants/acks against a latency-programmable memory.
module tb_risc_toy_mem_arb;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          I_REQ;
    logic [AW-1:0] I_ADDR;
    logic [DW-1:0] I_RDATA;
    logic          I_ACK;
    logic          D_REQ;
    logic          D_RW;
    logic [AW-1:0] D_ADDR;
    logic [DW-1:0] D_WDATA;
    logic [DW-1:0] D_RDATA;
    logic          D_ACK;
    logic          M_REQ;
    logic          M_RW;
    logic [AW-1:0] M_ADDR;
    logic [DW-1:0] M_WDATA;
    logic [DW-1:0] M_RDATA = '0;
    logic          M_ACK   = 1'b0;
    logic          BUSY;
    logic          TMO_ERR;

    always #5 CLK = ~CLK;

    risc_toy_mem_arb #(
        .AW        (AW),
        .DW        (DW),
        .MAX_D_RUN (4),
        .TMO       (64)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .I_REQ   (I_REQ),
        .I_ADDR  (I_ADDR),
        .I_RDATA (I_RDATA),
        .I_ACK   (I_ACK),
        .D_REQ   (D_REQ),
        .D_RW    (D_RW),
        .D_ADDR  (D_ADDR),
        .D_WDATA (D_WDATA),
        .D_RDATA (D_RDATA),
        .D_ACK   (D_ACK),
        .M_REQ   (M_REQ),
        .M_RW    (M_RW),
        .M_ADDR  (M_ADDR),
        .M_WDATA (M_WDATA),
        .M_RDATA (M_RDATA),
        .M_ACK   (M_ACK),
        .BUSY    (BUSY),
        .TMO_ERR (TMO_ERR)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 30'h10) return 32'h1234_5678;
        return {a[15:0], ~a[15:0]};
    endfunction

    typedef struct {
        logic [AW-1:0] addr;
        logic          rw;
        logic [DW-1:0] wdata;
    } gexp_t;

    gexp_t         gq[$];
    logic [DW-1:0] iq[$];
    logic [DW-1:0] dq[$];

    task automatic push_g(input logic [AW-1:0] a, input logic rw, input logic [DW-1:0] wd);
        gexp_t g;
        g.addr  = a;
        g.rw    = rw;
        g.wdata = wd;
        gq.push_back(g);
    endtask

    // Memory model: samples M_REQ like a registered slave, acks lat cycles later.
    int lat       = 1;
    bit no_ack    = 1'b0;
    bit force_ack = 1'b0;
    int rcnt      = 0;

    always @(negedge CLK) begin
        if (force_ack) begin
            M_ACK   = 1'b1;
            M_RDATA = 32'hDEAD_BEEF;
        end else if (M_REQ && !M_ACK && !no_ack) begin
            rcnt++;
            if (rcnt == lat + 1) begin
                M_ACK   = 1'b1;
                M_RDATA = mem_word(M_ADDR);
            end
        end else begin
            M_ACK   = 1'b0;
            M_RDATA = 32'h0BAD_0BAD;
            rcnt    = 0;
        end
    end

    // Scoreboard monitor: grants and acks are popped in order as the DUT produces them.
    logic m_req_prev = 1'b0;
    logic i_ack_prev = 1'b0;
    logic d_ack_prev = 1'b0;

    always @(negedge CLK) begin
        gexp_t g;
        if (M_REQ && !m_req_prev) begin
            check("grant_expected", gq.size() != 0, 1'b1);
            if (gq.size() != 0) begin
                g = gq.pop_front();
                check("grant_m_addr", M_ADDR, g.addr);
                check("grant_m_rw", M_RW, g.rw);
                if (g.rw) check("grant_m_wdata", M_WDATA, g.wdata);
            end
        end
        if (I_ACK) begin
            check("i_ack_one_cycle", i_ack_prev, 1'b0);
            check("i_ack_expected", iq.size() != 0, 1'b1);
            if (iq.size() != 0) check("i_rdata", I_RDATA, iq.pop_front());
        end
        if (D_ACK) begin
            check("d_ack_one_cycle", d_ack_prev, 1'b0);
            check("d_ack_expected", dq.size() != 0, 1'b1);
            if (dq.size() != 0) check("d_rdata", D_RDATA, dq.pop_front());
        end
        m_req_prev = M_REQ;
        i_ack_prev = I_ACK;
        d_ack_prev = D_ACK;
    end

    // Requesters hold REQ until their ACK; hold_d keeps D requesting until I completes.
    task automatic run(input int want_i, input int want_d, input bit hold_d, input int bound,
                       output int d_before_i, output int ncyc, output int mreq_n);
        int ni = 0;
        int nd = 0;
        bit done = 1'b0;
        d_before_i = -1;
        ncyc       = 0;
        mreq_n     = 0;
        for (int c = 0; c < bound && !done; c++) begin
            @(negedge CLK);
            ncyc++;
            if (M_REQ) mreq_n++;
            if (D_ACK) begin
                nd++;
                if (!hold_d) D_REQ = 1'b0;
            end
            if (I_ACK) begin
                ni++;
                if (ni == 1) d_before_i = nd;
                I_REQ = 1'b0;
                if (hold_d) D_REQ = 1'b0;
            end
            if (ni >= want_i && nd >= want_d) done = 1'b1;
        end
        check("run_completed", done, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_req"}, M_REQ, 1'b0);
        check({tag, "_m_rw"}, M_RW, 1'b0);
        check({tag, "_m_addr"}, M_ADDR, '0);
        check({tag, "_m_wdata"}, M_WDATA, '0);
        check({tag, "_i_rdata"}, I_RDATA, '0);
        check({tag, "_d_rdata"}, D_RDATA, '0);
        check({tag, "_i_ack"}, I_ACK, 1'b0);
        check({tag, "_d_ack"}, D_ACK, 1'b0);
        check({tag, "_busy"}, BUSY, 1'b0);
        check({tag, "_tmo_err"}, TMO_ERR, 1'b0);
    endtask

    initial begin
        int dbi;
        int ncyc;
        int mreq_n;
        bit seen;
        logic [DW-1:0] last_drd;

        RST = 1'b1; I_REQ = 1'b0; I_ADDR = '0;
        D_REQ = 1'b0; D_RW = 1'b0; D_ADDR = '0; D_WDATA = '0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b0;
        @(negedge CLK);

        // Single fetch, best-case latency.
        push_g(30'h10, 1'b0, '0);
        iq.push_back(32'h1234_5678);
        I_ADDR = 30'h10; I_REQ = 1'b1;
        run(1, 0, 1'b0, 20, dbi, ncyc, mreq_n);
        check("fetch_latency", ncyc, 3);
        check("fetch_m_req_dropped", M_REQ, 1'b0);

        // Data read, then a write that must leave D_RDATA alone.
        last_drd = mem_word(30'h44);
        push_g(30'h44, 1'b0, '0);
        dq.push_back(last_drd);
        D_ADDR = 30'h44; D_RW = 1'b0; D_REQ = 1'b1;
        run(0, 1, 1'b0, 20, dbi, ncyc, mreq_n);

        push_g(30'h20, 1'b1, 32'hCAFE_F00D);
        dq.push_back(last_drd);
        D_ADDR = 30'h20; D_RW = 1'b1; D_WDATA = 32'hCAFE_F00D; D_REQ = 1'b1;
        run(0, 1, 1'b0, 20, dbi, ncyc, mreq_n);
        D_RW = 1'b0;
        check("write_keeps_d_rdata", D_RDATA, last_drd);

        // Simultaneous requests: D wins first, then I.
        push_g(30'h48, 1'b0, '0);
        push_g(30'h14, 1'b0, '0);
        dq.push_back(mem_word(30'h48));
        iq.push_back(mem_word(30'h14));
        D_ADDR = 30'h48; I_ADDR = 30'h14; D_REQ = 1'b1; I_REQ = 1'b1;
        run(1, 1, 1'b0, 40, dbi, ncyc, mreq_n);
        check("both_d_first", dbi, 1);

        // D held continuously against a waiting I: run of 4 D grants, then I.
        for (int k = 0; k < 4; k++) begin
            push_g(30'h50, 1'b0, '0);
            dq.push_back(mem_word(30'h50));
        end
        push_g(30'h60, 1'b0, '0);
        iq.push_back(mem_word(30'h60));
        D_ADDR = 30'h50; I_ADDR = 30'h60; D_REQ = 1'b1; I_REQ = 1'b1;
        run(1, 4, 1'b1, 200, dbi, ncyc, mreq_n);
        check("d_run_length", dbi, 4);
        repeat (3) @(negedge CLK);
        check("d_run_idle_after", BUSY, 1'b0);

        // Stray M_ACK while idle must do nothing.
        force_ack = 1'b1;
        repeat (2) @(negedge CLK);
        force_ack = 1'b0;
        repeat (2) @(negedge CLK);
        check("stray_ack_busy", BUSY, 1'b0);
        check("stray_ack_m_req", M_REQ, 1'b0);
        check("stray_ack_i_rdata", I_RDATA, mem_word(30'h60));
        check("stray_ack_d_rdata", D_RDATA, mem_word(30'h50));

        // M_ACK arriving in the 64th grant cycle is a normal completion.
        lat = 63;
        push_g(30'h70, 1'b0, '0);
        iq.push_back(mem_word(30'h70));
        I_ADDR = 30'h70; I_REQ = 1'b1;
        run(1, 0, 1'b0, 100, dbi, ncyc, mreq_n);
        check("late_ack_cycles", ncyc, 65);
        check("late_ack_m_req_cycles", mreq_n, 64);
        check("late_ack_no_tmo", TMO_ERR, 1'b0);

        // No M_ACK at all: timeout after 64 grant cycles.
        lat = 1; no_ack = 1'b1;
        push_g(30'h30, 1'b0, '0);
        iq.push_back(32'hFFFF_FFFF);
        I_ADDR = 30'h30; I_REQ = 1'b1;
        run(1, 0, 1'b0, 100, dbi, ncyc, mreq_n);
        check("tmo_m_req_cycles", mreq_n, 64);
        check("tmo_m_req_dropped", M_REQ, 1'b0);
        check("tmo_err_set", TMO_ERR, 1'b1);
        no_ack = 1'b0;

        // TMO_ERR is sticky across a good transaction.
        push_g(30'h44, 1'b0, '0);
        dq.push_back(mem_word(30'h44));
        D_ADDR = 30'h44; D_REQ = 1'b1;
        run(0, 1, 1'b0, 20, dbi, ncyc, mreq_n);
        check("tmo_err_sticky", TMO_ERR, 1'b1);

        // Reset in the middle of a D grant: everything clears, no D_ACK follows.
        no_ack = 1'b1;
        push_g(30'h74, 1'b0, '0);
        D_ADDR = 30'h74; D_REQ = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge CLK);
            if (M_REQ) seen = 1'b1;
        end
        check("mid_grant_m_req_seen", seen, 1'b1);
        repeat (3) @(negedge CLK);
        RST = 1'b1; D_REQ = 1'b0;
        @(negedge CLK);
        check_all_zero("mid_reset");
        RST = 1'b0; no_ack = 1'b0;
        repeat (10) @(negedge CLK);
        check("post_reset_busy", BUSY, 1'b0);
        check("post_reset_d_ack", D_ACK, 1'b0);

        check("grant_queue_drained", gq.size(), 0);
        check("i_queue_drained", iq.size(), 0);
        check("d_queue_drained", dq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
